key_press_classifier: RTL and testbench
=======================================

KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 Parameter NUM_KEYS, default 6, SHALL set the number of classified keys (1..16).
REQ-002 Parameter KEY_MAP, default 24'h9_0_a_8_5_d, SHALL set the scan code of key i in bits [4i+3:4i].
REQ-003 Parameter CLK_DIV, default 50000, SHALL set the clk cycles per 1 ms tick.
REQ-004 Parameter DEBOUNCE_MS, default 20, SHALL set the press and release qualification time in ticks.
REQ-005 Parameter LONG_MS, default 1000, SHALL set the hold time in ticks to reach LONG.
REQ-006 Parameter REPEAT_MS, default 200, SHALL set the auto-repeat period in ticks.
REQ-007 clk  in  1  system clock; reset_n  in  1  reset, synchronous, active-low.
REQ-008 key_valid  in  1  scanner reports a key down.
REQ-009 key_code  in  4  scanner code, meaningful while key_valid=1.
REQ-010 key_state  out  2*NUM_KEYS  per key: 0 idle, 1 pressed, 2 long.
REQ-011 short_pulse  out  NUM_KEYS  one-clk pulse when a press is released before LONG.
REQ-012 long_pulse  out  NUM_KEYS  one-clk pulse on entering LONG.
REQ-013 repeat_pulse  out  NUM_KEYS  one-clk auto-repeat pulse; tied to 0 when the repeat feature is compiled out.

Function
REQ-014 The block SHALL run entirely on clk; the 1 ms tick SHALL be a one-clk enable, asserted when the divider reaches CLK_DIV-1, and SHALL never be used as a clock.
REQ-015 The FSM SHALL have states IDLE, DEBOUNCE, PRESSED, LONG, and RELEASE, and SHALL track one active key index.
REQ-016 In IDLE, key_valid=1 with a code in KEY_MAP SHALL latch that index, clear hold_cnt, and enter DEBOUNCE; unmapped codes SHALL be ignored.
REQ-017 hold_cnt SHALL be 16 bits, increment on each tick while the active code is held, and saturate at 16'hFFFF.
REQ-018 DEBOUNCE SHALL go to PRESSED when hold_cnt reaches DEBOUNCE_MS, and SHALL return to IDLE with no event if key_valid drops first.
REQ-019 PRESSED SHALL go to LONG when hold_cnt reaches LONG_MS, asserting long_pulse for that key.
REQ-020 In PRESSED or LONG, key_valid=0 SHALL enter RELEASE with rel_cnt cleared.
REQ-021 In RELEASE, key_valid=1 with the same code before rel_cnt reaches DEBOUNCE_MS SHALL return to the prior state with hold_cnt preserved, i.e. the glitch is ignored.
REQ-022 When rel_cnt reaches DEBOUNCE_MS, RELEASE SHALL go to IDLE, asserting short_pulse only if the prior state was PRESSED.
REQ-023 A different mapped code while in PRESSED, LONG, or RELEASE SHALL be treated as an immediate release of the old key (short_pulse if its prior state was PRESSED) plus entry to DEBOUNCE for the new key in the same clk.
REQ-024 key_state SHALL show 1 for the active key in PRESSED, 2 in LONG, the prior value during RELEASE, and 0 for all other keys.
REQ-025 All pulses SHALL be registered and last exactly one clk, asserted in the clk after the transition edge; at most one key's pulse bit SHALL be high at a time.

Reset
REQ-026 reset_n=0 SHALL synchronously clear the divider, hold_cnt, rel_cnt, and active index, set the FSM to IDLE, and drive key_state and all pulses to 0.
REQ-027 Reset asserted mid-press SHALL produce no pulse, and after reset the block SHALL require a full DEBOUNCE before reporting.

Configuration
REQ-028 Macro KEY_REPEAT_EN defined: in LONG, repeat_pulse SHALL fire every REPEAT_MS ticks, the first at LONG_MS+REPEAT_MS, via a repeat counter cleared on entry to LONG.
REQ-029 KEY_REPEAT_EN undefined: no repeat counter SHALL exist and repeat_pulse SHALL be constant 0.

Structure
REQ-030 Shared package key_pkg SHALL hold the FSM state encoding, the key_state encoding (IDLE=0, PRESSED=1, LONG=2), and the hold counter width constant.
REQ-031 The tick divider SHALL be sub-module key_tick_gen (parameter CLK_DIV, output tick).

Verification (CLK_DIV=4 for simulation, other parameters at default)
REQ-032 Code 4'h5 held for 50 ticks, then released for 25 ticks -> key_state[3:2]=1 from tick 20, one short_pulse[1] at tick 70, no long_pulse.
REQ-033 Code 4'hd held for 1200 ticks -> long_pulse[0] at tick 1000, key_state[1:0]=2, no short_pulse on release; with KEY_REPEAT_EN, repeat_pulse[0] at ticks 1200 only.
REQ-034 Code 4'h8 held 10 ticks then released -> no state change, no pulses.
REQ-035 Code 4'h0 held 100 ticks, key_valid low for 5 ticks, held 900 more -> no short_pulse; long_pulse[4] at cumulative hold tick 1000.
REQ-036 Code 4'ha in PRESSED switched directly to 4'h9 -> short_pulse[3] immediately, key5 pressed 20 ticks later; unmapped 4'h3 -> no activity.
REQ-037 reset_n pulsed low at tick 500 of a 4'hd hold -> all outputs 0, no pulses, re-press is reported after 20 ticks.

Source files
------------

// File: rtl/key_pkg.sv
// Shared encodings for the key press classifier: FSM states, per-key
// report codes and the hold counter width.
package key_pkg;

    localparam int HOLD_W = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_PRESSED  = 3'd2;
    localparam logic [2:0] ST_LONG     = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    localparam logic [1:0] KS_IDLE    = 2'd0;
    localparam logic [1:0] KS_PRESSED = 2'd1;
    localparam logic [1:0] KS_LONG    = 2'd2;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_press_classifier_if.sv
// Scanner-to-classifier bus. key_valid is a level (no ready); key_code is
// only meaningful while key_valid is high.
interface key_press_classifier_if;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input key_valid, input key_code);
endinterface

// File: rtl/key_tick_gen.sv
// Free-running divider producing a one-clk enable every CLK_DIV cycles.
module key_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        tick  = (div_q == DW'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= div_d;
    end
endmodule

// File: rtl/key_press_classifier.sv
// Debounces one active scanner key and classifies it as short/long press.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a key is held LONG.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int                    NUM_KEYS    = 6,
    parameter logic [4*NUM_KEYS-1:0] KEY_MAP     = 24'h9_0_a_8_5_d,
    parameter int                    CLK_DIV     = 50000,
    parameter int                    DEBOUNCE_MS = 20,
    parameter int                    LONG_MS     = 1000,
    parameter int                    REPEAT_MS   = 200
) (
    input  logic                      clk,
    input  logic                      reset_n,
    key_press_classifier_if.slave     scan,
    output logic [2*NUM_KEYS-1:0]     key_state,
    output logic [NUM_KEYS-1:0]       short_pulse,
    output logic [NUM_KEYS-1:0]       long_pulse,
    output logic [NUM_KEYS-1:0]       repeat_pulse,
    output logic [2:0]                dbg_state
);
    if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_cfg
        $error("key_press_classifier: illegal parameter set");
    end

    logic tick;

    key_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset_n(reset_n), .tick(tick));

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              prior_long_q, prior_long_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] rel_cnt_q, rel_cnt_d;
    logic [NUM_KEYS-1:0] short_q, short_d, long_q, long_d;

    logic       map_hit, held, other, restart, fire_short, fire_long;
    logic [3:0] hit_idx, active_code;
    logic [1:0] ks_active;

`ifdef KEY_REPEAT_EN
    logic [HOLD_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic                fire_rep;
`endif

    // Lowest index wins if a code appears more than once in the map.
    always_comb begin
        map_hit     = 1'b0;
        hit_idx     = '0;
        active_code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (scan.key_code == KEY_MAP[4*i +: 4]) begin
                map_hit = scan.key_valid;
                hit_idx = 4'(i);
            end
            if (idx_q == 4'(i)) active_code = KEY_MAP[4*i +: 4];
        end
        held  = scan.key_valid && (scan.key_code == active_code);
        other = map_hit && !held;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        prior_long_d = prior_long_q;
        hold_cnt_d   = (tick && held) ? sat_inc(hold_cnt_q) : hold_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        restart      = 1'b0;
        fire_short   = 1'b0;
        fire_long    = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d    = rep_cnt_q;
        fire_rep     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: restart = map_hit;
            ST_DEBOUNCE: begin
                if (other)                                     restart = 1'b1;
                else if (!held)                                state_d = ST_IDLE;
                else if (hold_cnt_q >= HOLD_W'(DEBOUNCE_MS))   state_d = ST_PRESSED;
            end
            ST_PRESSED, ST_LONG: begin
                if (other) begin
                    restart    = 1'b1;
                    fire_short = (state_q == ST_PRESSED);
                end else if (!scan.key_valid) begin
                    state_d      = ST_RELEASE;
                    rel_cnt_d    = '0;
                    prior_long_d = (state_q == ST_LONG);
                end else if (state_q == ST_PRESSED && hold_cnt_q >= HOLD_W'(LONG_MS)) begin
                    state_d   = ST_LONG;
                    fire_long = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d = '0;
                end else if (state_q == ST_LONG && held && tick) begin
                    fire_rep  = (rep_cnt_q >= HOLD_W'(REPEAT_MS - 1));
                    rep_cnt_d = fire_rep ? '0 : rep_cnt_q + 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                if (other) begin
                    restart    = 1'b1;
                    fire_short = !prior_long_q;
                end else if (held) begin
                    // Short glitch: resume where we left off, counts intact.
                    state_d = prior_long_q ? ST_LONG : ST_PRESSED;
                end else if (rel_cnt_q >= HOLD_W'(DEBOUNCE_MS)) begin
                    state_d    = ST_IDLE;
                    fire_short = !prior_long_q;
                end else if (tick) begin
                    rel_cnt_d = sat_inc(rel_cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            idx_d      = hit_idx;
            hold_cnt_d = '0;
            state_d    = ST_DEBOUNCE;
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
            short_d[i] = fire_short && (idx_q == 4'(i));
            long_d[i]  = fire_long && (idx_q == 4'(i));
`ifdef KEY_REPEAT_EN
            repeat_d[i] = fire_rep && (idx_q == 4'(i));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            prior_long_q <= 1'b0;
            hold_cnt_q   <= '0;
            rel_cnt_q    <= '0;
            short_q      <= '0;
            long_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            prior_long_q <= prior_long_d;
            hold_cnt_q   <= hold_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            short_q      <= short_d;
            long_q       <= long_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_cnt_q <= '0;
            repeat_q  <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = '0;
`endif

    always_comb begin
        case (state_q)
            ST_PRESSED: ks_active = KS_PRESSED;
            ST_LONG:    ks_active = KS_LONG;
            ST_RELEASE: ks_active = prior_long_q ? KS_LONG : KS_PRESSED;
            default:    ks_active = KS_IDLE;
        endcase
        key_state = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (idx_q == 4'(i)) key_state[2*i +: 2] = ks_active;
        end
    end

    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_key_press_classifier.sv
// Self-checking bench for key_press_classifier (CLK_DIV=4, other params default).
module tb_key_press_classifier;
    localparam int NK      = 6;
    localparam int CLK_DIV = 4;
    localparam int DEB     = 20;
    localparam int LONG_T  = 1000;
    localparam int REP_T   = 200;
    localparam int TOL     = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    key_press_classifier_if scan_if ();

    logic [2*NK-1:0] key_state;
    logic [NK-1:0]   short_pulse, long_pulse, repeat_pulse;
    logic [2:0]      dbg_state;

    key_press_classifier #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan         (scan_if),
        .key_state    (key_state),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .dbg_state    (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pulse_err = 0;
    logic [23:0] map_v = 24'h9_0_a_8_5_d;

    // observed pulse events: {type, key}, type 1=short 2=long 3=repeat
    logic [7:0] obs_q[$];
    int         obs_t[$];
    logic [7:0] exp_q[$];
    int         exp_t[$];
    logic [NK-1:0] prev_s = '0, prev_l = '0, prev_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NK; i++) begin
            if (short_pulse[i])  begin obs_q.push_back({4'd1, 4'(i)}); obs_t.push_back(cyc); end
            if (long_pulse[i])   begin obs_q.push_back({4'd2, 4'(i)}); obs_t.push_back(cyc); end
            if (repeat_pulse[i]) begin obs_q.push_back({4'd3, 4'(i)}); obs_t.push_back(cyc); end
        end
        if ($countones(short_pulse) > 1 || $countones(long_pulse) > 1 || $countones(repeat_pulse) > 1)
            pulse_err++;
        if ((short_pulse & prev_s) != 0 || (long_pulse & prev_l) != 0 || (repeat_pulse & prev_r) != 0)
            pulse_err++;
        prev_s = short_pulse;
        prev_l = long_pulse;
        prev_r = repeat_pulse;
    end

    function automatic int count_ev(input int ty, input int key);
        int n = 0;
        foreach (obs_q[j]) if (obs_q[j] == {4'(ty), 4'(key)}) n++;
        return n;
    endfunction

    function automatic int ev_tick(input int ty, input int key);
        foreach (obs_q[j]) if (obs_q[j] == {4'(ty), 4'(key)}) return (obs_t[j] - start_cyc) / CLK_DIV;
        return -1;
    endfunction

    function automatic logic [1:0] ks(input int k);
        return key_state[2*k +: 2];
    endfunction

    task automatic begin_scn();
        obs_q.delete();
        obs_t.delete();
        start_cyc = cyc;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        scan_if.key_valid = 1'b1;
        scan_if.key_code  = c;
    endtask

    task automatic release_key();
        scan_if.key_valid = 1'b0;
        scan_if.key_code  = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        scan_if.key_valid = 1'b0;
        scan_if.key_code  = 4'h0;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_state !== '0) begin failures++; $display("FAIL reset_key_state: got %h expected 0", key_state); end
        checks++;
        if ({short_pulse, long_pulse, repeat_pulse} !== '0) begin
            failures++; $display("FAIL reset_pulses: got %h expected 0", {short_pulse, long_pulse, repeat_pulse});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        begin_scn();
        wait_ticks(5);
        checks++;
        if (key_state !== '0 || obs_q.size() != 0) begin
            failures++; $display("FAIL idle_after_reset: got state %h events %0d expected 0 0", key_state, obs_q.size());
        end
    endtask

    task automatic test_short();
        begin_scn();
        press(4'h5);
        wait_ticks(15);
        checks++;
        if (ks(1) !== 2'd0) begin failures++; $display("FAIL short_debouncing: got %0d expected 0", ks(1)); end
        wait_ticks(8);
        checks++;
        if (key_state !== 12'h004) begin failures++; $display("FAIL short_pressed: got %h expected 004", key_state); end
        wait_ticks(27);
        release_key();
        wait_ticks(25);
        checks++;
        if (count_ev(1, 1) != 1 || obs_q.size() != 1) begin
            failures++; $display("FAIL short_events: got short1=%0d total=%0d expected 1 1", count_ev(1, 1), obs_q.size());
        end
        checks++;
        if (ev_tick(1, 1) < 70 - TOL || ev_tick(1, 1) > 70 + TOL) begin
            failures++; $display("FAIL short_time: got tick %0d expected 70", ev_tick(1, 1));
        end
    endtask

    task automatic test_long();
        int exp_rep;
`ifdef KEY_REPEAT_EN
        exp_rep = 1;
`else
        exp_rep = 0;
`endif
        begin_scn();
        press(4'hd);
        wait_ticks(900);
        checks++;
        if (key_state !== 12'h001) begin failures++; $display("FAIL long_pressed: got %h expected 001", key_state); end
        wait_ticks(200);
        checks++;
        if (key_state !== 12'h002) begin failures++; $display("FAIL long_state: got %h expected 002", key_state); end
        wait_ticks(110);
        release_key();
        wait_ticks(5);
        checks++;
        if (key_state !== 12'h002) begin failures++; $display("FAIL long_release_hold: got %h expected 002", key_state); end
        wait_ticks(25);
        checks++;
        if (key_state !== '0) begin failures++; $display("FAIL long_back_idle: got %h expected 0", key_state); end
        checks++;
        if (count_ev(2, 0) != 1 || count_ev(1, 0) != 0 || count_ev(3, 0) != exp_rep) begin
            failures++; $display("FAIL long_events: got long=%0d short=%0d rep=%0d expected 1 0 %0d",
                                 count_ev(2, 0), count_ev(1, 0), count_ev(3, 0), exp_rep);
        end
        checks++;
        if (ev_tick(2, 0) < LONG_T - TOL || ev_tick(2, 0) > LONG_T + TOL) begin
            failures++; $display("FAIL long_time: got tick %0d expected %0d", ev_tick(2, 0), LONG_T);
        end
        if (exp_rep == 1) begin
            checks++;
            if (ev_tick(3, 0) < 1200 - TOL || ev_tick(3, 0) > 1200 + TOL) begin
                failures++; $display("FAIL repeat_time: got tick %0d expected 1200", ev_tick(3, 0));
            end
        end
    endtask

    task automatic test_bounce();
        begin_scn();
        press(4'h8);
        wait_ticks(10);
        checks++;
        if (key_state !== '0) begin failures++; $display("FAIL bounce_state: got %h expected 0", key_state); end
        release_key();
        wait_ticks(30);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_events: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_glitch();
        begin_scn();
        press(4'h0);
        wait_ticks(100);
        release_key();
        wait_ticks(2);
        checks++;
        if (ks(4) !== 2'd1) begin failures++; $display("FAIL glitch_prior_state: got %0d expected 1", ks(4)); end
        wait_ticks(3);
        press(4'h0);
        wait_ticks(950);
        release_key();
        wait_ticks(30);
        checks++;
        if (count_ev(1, 4) != 0 || count_ev(2, 4) != 1) begin
            failures++; $display("FAIL glitch_events: got short=%0d long=%0d expected 0 1", count_ev(1, 4), count_ev(2, 4));
        end
        checks++;
        if (ev_tick(2, 4) < 1005 - TOL || ev_tick(2, 4) > 1005 + TOL) begin
            failures++; $display("FAIL glitch_long_time: got tick %0d expected 1005", ev_tick(2, 4));
        end
    endtask

    task automatic test_switch();
        begin_scn();
        press(4'ha);
        wait_ticks(40);
        checks++;
        if (ks(3) !== 2'd1) begin failures++; $display("FAIL switch_old_pressed: got %0d expected 1", ks(3)); end
        press(4'h9);
        wait_ticks(10);
        checks++;
        if (key_state !== '0) begin failures++; $display("FAIL switch_new_debounce: got %h expected 0", key_state); end
        checks++;
        if (count_ev(1, 3) != 1 || ev_tick(1, 3) < 40 - TOL || ev_tick(1, 3) > 40 + TOL) begin
            failures++; $display("FAIL switch_short_old: got count %0d tick %0d expected 1 40", count_ev(1, 3), ev_tick(1, 3));
        end
        wait_ticks(12);
        checks++;
        if (key_state !== 12'h400) begin failures++; $display("FAIL switch_new_pressed: got %h expected 400", key_state); end
        wait_ticks(18);
        release_key();
        wait_ticks(30);
        checks++;
        if (count_ev(1, 5) != 1 || ev_tick(1, 5) < 100 - TOL || ev_tick(1, 5) > 100 + TOL) begin
            failures++; $display("FAIL switch_short_new: got count %0d tick %0d expected 1 100", count_ev(1, 5), ev_tick(1, 5));
        end
        begin_scn();
        press(4'h3);
        wait_ticks(30);
        checks++;
        if (key_state !== '0) begin failures++; $display("FAIL unmapped_state: got %h expected 0", key_state); end
        release_key();
        wait_ticks(30);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL unmapped_events: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        begin_scn();
        press(4'hd);
        wait_ticks(500);
        checks++;
        if (ks(0) !== 2'd1) begin failures++; $display("FAIL rstmid_pressed: got %0d expected 1", ks(0)); end
        reset_n = 1'b0;
        release_key();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_state !== '0 || {short_pulse, long_pulse, repeat_pulse} !== '0) begin
            failures++; $display("FAIL rstmid_outputs: got state %h pulses %h expected 0 0",
                                 key_state, {short_pulse, long_pulse, repeat_pulse});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_ticks(30);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_no_pulse: got %0d expected 0", obs_q.size()); end
        begin_scn();
        press(4'hd);
        wait_ticks(10);
        checks++;
        if (ks(0) !== 2'd0) begin failures++; $display("FAIL rstmid_redebounce: got %0d expected 0", ks(0)); end
        wait_ticks(12);
        checks++;
        if (ks(0) !== 2'd1) begin failures++; $display("FAIL rstmid_repress: got %0d expected 1", ks(0)); end
        release_key();
        wait_ticks(30);
        checks++;
        if (count_ev(1, 0) != 1 || ev_tick(1, 0) < 42 - TOL || ev_tick(1, 0) > 42 + TOL) begin
            failures++; $display("FAIL rstmid_short: got count %0d tick %0d expected 1 42", count_ev(1, 0), ev_tick(1, 0));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int k, h;
            logic [3:0] code;
            k = $urandom_range(0, NK - 1);
            code = map_v[4*k +: 4];
            h = $urandom_range(25, 1150);
            if (h >= LONG_T - 4 && h <= LONG_T + 4) h = LONG_T + 10;
            if (h >= LONG_T + REP_T - 4 && h <= LONG_T + REP_T + 4) h = LONG_T + REP_T + 8;
            exp_q.delete();
            exp_t.delete();
            if (h < LONG_T) begin
                exp_q.push_back({4'd1, 4'(k)}); exp_t.push_back(h + DEB);
            end else begin
                exp_q.push_back({4'd2, 4'(k)}); exp_t.push_back(LONG_T);
`ifdef KEY_REPEAT_EN
                for (int t = LONG_T + REP_T; t < h; t += REP_T) begin
                    exp_q.push_back({4'd3, 4'(k)}); exp_t.push_back(t);
                end
`endif
            end
            begin_scn();
            press(code);
            wait_ticks(22);
            checks++;
            if (key_state !== (12'h001 << (2 * k))) begin
                failures++; $display("FAIL rand_pressed[%0d]: got %h expected %h", it, key_state, 12'h001 << (2 * k));
            end
            if (h > LONG_T + 5) begin
                wait_ticks(LONG_T + 3 - 22);
                checks++;
                if (key_state !== (12'h002 << (2 * k))) begin
                    failures++; $display("FAIL rand_long[%0d]: got %h expected %h", it, key_state, 12'h002 << (2 * k));
                end
                wait_ticks(h - LONG_T - 3);
            end else begin
                wait_ticks(h - 22);
            end
            release_key();
            wait_ticks(30);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand_count[%0d]: got %0d events expected %0d (hold %0d)", it, obs_q.size(), exp_q.size(), h);
            end
            for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
                checks++;
                if (obs_q[j] !== exp_q[j] || (obs_t[j] - start_cyc) / CLK_DIV < exp_t[j] - TOL ||
                    (obs_t[j] - start_cyc) / CLK_DIV > exp_t[j] + TOL) begin
                    failures++; $display("FAIL rand_event[%0d.%0d]: got %h at tick %0d expected %h at tick %0d",
                                         it, j, obs_q[j], (obs_t[j] - start_cyc) / CLK_DIV, exp_q[j], exp_t[j]);
                end
            end
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (pulse_err != 0) begin failures++; $display("FAIL pulse_shape: got %0d violations expected 0", pulse_err); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_bounce();
        test_glitch();
        test_switch();
        test_reset_mid();
        test_random();
        test_pulse_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
